// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
package rr_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/rr_pick.sv
// Rotate-priority scan: first set request bit starting at ptr, wrapping mod 4.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               ptr,
    output logic               found,
    output idx_t               idx
);

    idx_t w_cand;

    // Scan from the far end back toward ptr so the closest set bit wins.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = ptr + idx_t'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter feeding decoder2to4; grant held until done or owner drops req.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int CNT_W = 8
`ifdef RR_ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               gnt_valid,
    output idx_t               gnt_idx,
    output logic [CNT_W-1:0]   gnt_count,
    output logic               timeout
);

    arb_state_t r_state;
    idx_t       r_ptr;
    logic       w_found;
    idx_t       w_pick_idx;
    logic       w_release;

    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_release = done | ~req[gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       w_expire;

    // r_hold counts GRANT cycles already completed, so the limit hits on cycle MAX_HOLD.
    assign w_expire = (r_hold == 8'(MAX_HOLD - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_count <= '0;
            timeout   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold    <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state   <= GRANT;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= w_pick_idx;
                        if (gnt_count != '1)
                            gnt_count <= gnt_count + CNT_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
                        r_hold    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state   <= IDLE;
                        gnt_valid <= 1'b0;
                        r_ptr     <= gnt_idx + idx_t'(1);
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (w_expire) begin
                        r_state   <= IDLE;
                        gnt_valid <= 1'b0;
                        r_ptr     <= gnt_idx + idx_t'(1);
                        timeout   <= 1'b1;
                    end else begin
                        r_hold    <= r_hold + 8'd1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4; a second instance with CNT_W=2 covers saturation.
module tb_rr_arbiter4;
    import rr_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic       gnt_valid, s_valid;
    idx_t       gnt_idx, s_idx;
    logic [7:0] gnt_count;
    logic [1:0] s_count;
    logic       timeout, s_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef RR_ARB_TIMEOUT_EN
    rr_arbiter4 #(.CNT_W(8), .MAX_HOLD(4)) u_dut (
`else
    rr_arbiter4 #(.CNT_W(8)) u_dut (
`endif
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
        .gnt_count(gnt_count), .timeout(timeout)
    );

`ifdef RR_ARB_TIMEOUT_EN
    rr_arbiter4 #(.CNT_W(2), .MAX_HOLD(4)) u_sat (
`else
    rr_arbiter4 #(.CNT_W(2)) u_sat (
`endif
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_valid(s_valid), .gnt_idx(s_idx),
        .gnt_count(s_count), .timeout(s_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_rot [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(gnt_valid), 0);
        check("rst_idx",   32'(gnt_idx),   0);
        check("rst_count", 32'(gnt_count), 0);
        check("rst_tmo",   32'(timeout),   0);
        check("rst_sat",   32'(s_count),   0);

        rst = 1'b0;
        tick();
        // Rotation with req all ones, done one cycle after each grant.
        for (int i = 0; i < 5; i++) begin
            check("rot_valid", 32'(gnt_valid), 1);
            check("rot_idx",   32'(gnt_idx),   32'(exp_rot[i]));
            check("rot_count", 32'(gnt_count), 32'(i + 1));
            check("sat_count", 32'(s_count),   32'((i + 1 > 3) ? 3 : i + 1));
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rot_gap", 32'(gnt_valid), 0);
            if (i < 4) tick();
        end
        check("rot_total", 32'(gnt_count), 5);
        check("sat_stick", 32'(s_count),   3);

        // ptr=1 now; force a grant to 2, then wrap with req=0011.
        req = 4'b0100;
        tick();
        check("g2_idx", 32'(gnt_idx), 2);
        req = 4'b0011;
        tick();
        check("g2_drop", 32'(gnt_valid), 0);
        tick();
        check("wrap_valid", 32'(gnt_valid), 1);
        check("wrap_idx",   32'(gnt_idx),   0);
        check("wrap_count", 32'(gnt_count), 7);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wrap_rel", 32'(gnt_valid), 0);
        tick();
        check("wrap_next", 32'(gnt_idx), 1);

        // Owner drop: req[1] falls without done; next grant skips to 2.
        req = 4'b0100;
        tick();
        check("drop_valid", 32'(gnt_valid), 0);
        check("drop_hold",  32'(gnt_idx),   1);
        tick();
        check("skip_idx",   32'(gnt_idx),   2);
        check("skip_count", 32'(gnt_count), 9);
        req = 4'b1101;
        tick();
        check("other_req_ign", 32'(gnt_valid), 1);
        check("other_req_idx", 32'(gnt_idx),   2);
        done = 1'b1;
        tick();
        check("rel2", 32'(gnt_valid), 0);
        req = 4'b0000;
        tick();
        check("idle_done_ign", 32'(gnt_valid), 0);
        done = 1'b0;
        req = 4'b1001;
        tick();
        check("g3_idx",   32'(gnt_idx),   3);
        check("g3_count", 32'(gnt_count), 10);

`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_valid", 32'(gnt_valid), 1);
            check("hold_tmo",   32'(timeout),   0);
        end
        tick();
        check("tmo_valid", 32'(gnt_valid), 0);
        check("tmo_pulse", 32'(timeout),   1);
        tick();
        check("tmo_clear", 32'(timeout),   0);
        check("tmo_next",  32'(gnt_idx),   0);
        check("tmo_nextv", 32'(gnt_valid), 1);
        for (int c = 0; c < 3; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done4_valid", 32'(gnt_valid), 0);
        check("done4_tmo",   32'(timeout),   0);
`else
        for (int c = 0; c < 6; c++) begin
            tick();
            check("hold_valid", 32'(gnt_valid), 1);
            check("hold_idx",   32'(gnt_idx),   3);
            check("hold_tmo",   32'(timeout),   0);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("hold_rel", 32'(gnt_valid), 0);
`endif

        // Reset in the middle of a grant.
        tick();
        check("pre_rst_valid", 32'(gnt_valid), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(gnt_valid), 0);
        check("mid_rst_count", 32'(gnt_count), 0);
        check("mid_rst_sat",   32'(s_count),   0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("post_rst_idx",   32'(gnt_idx),   0);
        check("post_rst_count", 32'(gnt_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
